// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: op codes, FSM states
// and the op-legality check.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // True for the five op codes the ALU implements.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_MUL) || (op == ALU_SUB) ||
           (op == ALU_AND) || (op == ALU_OR);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request and response channels between the issue stages and the ALU
// sharing controller. The issue side is the master, the controller the slave.
interface alu_share_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;
  logic              resp_zero;
  logic              resp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data, resp_zero, resp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_share_ctrl_arb.sv
// Two-way round-robin arbiter. A lone requester always wins; on contention
// the requester that did not win last time gets the grant. The pointer only
// moves when a grant is actually taken.
module rr_arbiter2 #(
  parameter int RR_INIT = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic accept_i,
  output logic grant0_o,
  output logic grant1_o
);

  // last_grant resets to the requester that does NOT hold priority.
  localparam logic LAST_RST = (RR_INIT == 0) ? 1'b1 : 1'b0;

  logic last_q;
  logic last_d;

  // Grant decode from the requests and the last winner.
  always_comb begin
    grant0_o = valid0_i & (~valid1_i | last_q);
    grant1_o = valid1_i & (~valid0_i | ~last_q);
    last_d   = last_q;
    if (accept_i) begin
      last_d = grant1_o;
    end
  end

  // Last-winner register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= LAST_RST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between two requesters. One op is in flight at
// a time: IDLE accepts, EXEC presents operands, CAPT grabs the ALU result,
// RESP holds the response until the consumer takes it.
//
//  state | meaning
//  IDLE  | ready follows arbiter grant; accept latches op/operands
//  EXEC  | operand regs drive the ALU, ALU samples at end of cycle
//  CAPT  | ALU result registered into the response, zero/err set
//  RESP  | resp_valid high until resp_ready
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int RR_INIT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_share_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_data1_o,
  output logic [DATA_W-1:0] alu_data2_o,
  output logic [2:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic [CNT_W-1:0]  grant_cnt0_o,
  output logic [CNT_W-1:0]  grant_cnt1_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              grant0, grant1;
  logic              idle, accept;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              id_q;
  logic [DATA_W-1:0] data_q;
  logic              zero_q, err_q;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle & (grant0 | grant1);

  rr_arbiter2 #(.RR_INIT(RR_INIT)) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid0_i (bus.req0_valid),
    .valid1_i (bus.req1_valid),
    .accept_i (accept),
    .grant0_o (grant0),
    .grant1_o (grant1)
  );

  assign bus.req0_ready = idle & grant0;
  assign bus.req1_ready = idle & grant1;

  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_zero  = zero_q;
  assign bus.resp_err   = err_q;

  // Illegal codes run as AND so the ALU still produces a defined result.
  assign alu_data1_o  = a_q;
  assign alu_data2_o  = b_q;
  assign alu_ctrl_o   = op_legal(op_q) ? op_q : ALU_AND;
  assign grant_cnt0_o = cnt0_q;
  assign grant_cnt1_o = cnt1_q;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on accept; held through RESP so the ALU output is stable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      op_q <= grant1 ? bus.req1_op : bus.req0_op;
      a_q  <= grant1 ? bus.req1_a  : bus.req0_a;
      b_q  <= grant1 ? bus.req1_b  : bus.req0_b;
      id_q <= grant1;
    end
  end

  // Response capture from the registered ALU output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state_q == ST_CAPT) begin
      data_q <= alu_data_i;
      zero_q <= (alu_data_i == '0);
      err_q  <= ~op_legal(op_q);
    end
  end

  // Saturating per-requester grant counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (grant0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_ONE;
      if (grant1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural registered ALU.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.DATA_W(DW)) bus ();

  logic [DW-1:0] alu_d1, alu_d2;
  logic [DW-1:0] alu_q = '0;
  logic [2:0]    alu_ctrl;
  logic [CW-1:0] cnt0, cnt1;

  alu_share_ctrl #(.DATA_W(DW), .CNT_W(CW), .RR_INIT(0)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .alu_data1_o  (alu_d1),
    .alu_data2_o  (alu_d2),
    .alu_ctrl_o   (alu_ctrl),
    .alu_data_i   (alu_q),
    .grant_cnt0_o (cnt0),
    .grant_cnt1_o (cnt1)
  );

  // Registered ALU
  always @(posedge clk) begin
    case (alu_ctrl)
      3'b010:  alu_q <= alu_d1 + alu_d2;
      3'b100:  alu_q <= alu_d1 * alu_d2;
      3'b110:  alu_q <= alu_d1 - alu_d2;
      3'b000:  alu_q <= alu_d1 & alu_d2;
      3'b001:  alu_q <= alu_d1 | alu_d2;
      default: alu_q <= '0;
    endcase
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Issue one op, check ALU drive in EXEC and the accept-to-resp latency.
  // Returns at the negedge of the first RESP cycle.
  task automatic issue(input bit id, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [2:0] exp_ctrl, input string tag);
    bit got;
    int n;
    @(negedge clk);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    #1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (id ? bus.req1_ready : bus.req0_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk({tag, ".accept"}, got, 1);
    if (!got) begin
      clear_reqs();
      return;
    end
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    chk({tag, ".ctrl"}, alu_ctrl, exp_ctrl);
    chk({tag, ".d1"}, alu_d1, a);
    n = 1;
    while (!bus.resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, 3);
  endtask

  task automatic chk_resp(input string tag, input bit id, input logic [DW-1:0] data,
                          input bit zero, input bit err);
    chk({tag, ".valid"}, bus.resp_valid, 1);
    chk({tag, ".id"}, bus.resp_id, id);
    chk({tag, ".data"}, bus.resp_data, data);
    chk({tag, ".zero"}, bus.resp_zero, zero);
    chk({tag, ".err"}, bus.resp_err, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    int ids[4];
    logic [DW-1:0] dat[4];
    int cyc[4];
    int nresp;
    clear_reqs();
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst.valid", bus.resp_valid, 0);
    chk("rst.data", bus.resp_data, 0);
    chk("rst.id", bus.resp_id, 0);
    chk("rst.zero", bus.resp_zero, 0);
    chk("rst.err", bus.resp_err, 0);
    chk("rst.d1", alu_d1, 0);
    chk("rst.d2", alu_d2, 0);
    chk("rst.ctrl", alu_ctrl, 0);
    chk("rst.cnt0", cnt0, 0);
    chk("rst.cnt1", cnt1, 0);
    chk("rst.rdy0", bus.req0_ready, 0);
    chk("rst.rdy1", bus.req1_ready, 0);

    // 1: req0 add
    issue(1'b0, ALU_ADD, 32'd5, 32'd7, 3'b010, "t1");
    chk_resp("t1", 1'b0, 32'd12, 1'b0, 1'b0);

    // 2: req1 sub to zero
    issue(1'b1, ALU_SUB, 32'd9, 32'd9, 3'b110, "t2");
    chk_resp("t2", 1'b1, 32'd0, 1'b1, 1'b0);

    // 3: both requesters valid every cycle
    pulse_reset();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op = ALU_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
    bus.req1_valid = 1'b1; bus.req1_op = ALU_OR;  bus.req1_a = 32'd4; bus.req1_b = 32'd8;
    nresp = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        ids[nresp] = int'(bus.resp_id);
        dat[nresp] = bus.resp_data;
        cyc[nresp] = k;
        nresp++;
        if (nresp == 4) begin
          clear_reqs();
          break;
        end
      end
    end
    clear_reqs();
    chk("t3.nresp", nresp, 4);
    if (nresp == 4) begin
      chk("t3.id0", ids[0], 0);
      chk("t3.id1", ids[1], 1);
      chk("t3.id2", ids[2], 0);
      chk("t3.id3", ids[3], 1);
      chk("t3.dat0", dat[0], 32'd3);
      chk("t3.dat1", dat[1], 32'd12);
      chk("t3.gap1", cyc[1] - cyc[0], 4);
      chk("t3.gap3", cyc[3] - cyc[2], 4);
    end
    @(negedge clk);
    chk("t3.cnt0", cnt0, 2);
    chk("t3.cnt1", cnt1, 2);
    chk("t3.idle", bus.resp_valid, 0);

    // 4: mul truncation
    issue(1'b0, ALU_MUL, 32'h0001_0000, 32'h0001_0000, 3'b100, "t4");
    chk_resp("t4", 1'b0, 32'd0, 1'b1, 1'b0);

    // 5: illegal op runs as AND, flagged
    issue(1'b0, 3'b111, 32'd6, 32'd3, 3'b000, "t5");
    chk_resp("t5", 1'b0, 32'd2, 1'b0, 1'b1);
    chk("t5.cnt0", cnt0, 4);

    // Counter saturation at all-ones
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, ALU_ADD, DW'(i), 32'd1, 3'b010, "sat");
      chk("sat.data", bus.resp_data, DW'(i + 1));
      chk("sat.cnt0", cnt0, ((5 + i) > 7) ? 7 : (5 + i));
    end
    chk("sat.cnt1", cnt1, 2);

    // 6a: reset during EXEC
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op = ALU_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    #1;
    chk("t6a.rdy_pre", bus.req0_ready, 1);
    @(posedge clk); #1;
    chk("t6a.exec_rdy", bus.req0_ready, 0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("t6a.rdy", bus.req0_ready, 1);
    chk("t6a.cnt0", cnt0, 0);
    chk("t6a.cnt1", cnt1, 0);
    clear_reqs();
    for (int i = 0; i < 6; i++) begin
      chk("t6a.novalid", bus.resp_valid, 0);
      @(negedge clk);
    end

    // 6b: response held under backpressure
    bus.resp_ready = 1'b0;
    issue(1'b1, ALU_ADD, 32'd100, 32'd23, 3'b010, "t6b");
    chk_resp("t6b", 1'b1, 32'd123, 1'b0, 1'b0);
    bus.req0_valid = 1'b1; bus.req0_op = ALU_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_op = ALU_ADD; bus.req1_a = 32'd2; bus.req1_b = 32'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6b.hold_valid", bus.resp_valid, 1);
      chk("t6b.hold_data", bus.resp_data, 32'd123);
      chk("t6b.hold_id", bus.resp_id, 1);
      chk("t6b.rdy0", bus.req0_ready, 0);
      chk("t6b.rdy1", bus.req1_ready, 0);
    end
    clear_reqs();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("t6b.released", bus.resp_valid, 0);
    chk("t6b.cnt1", cnt1, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
